// File: rtl/bissc_slave.sv
// BiSS-C slave transmitter: oversamples the master's MA clock on enc_clk and shifts one sensor frame out on slo.
// Optional CRC6 generation is enabled by defining BISSC_SLAVE_CRC_EN; otherwise the CRC bit periods carry 0.
module bissc_slave #(
  parameter int DATA_W      = 26,
  parameter int ACK_LEN     = 1,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic              enc_clk,
  input  logic              rst_n,
  input  logic              ma_in,
  input  logic [DATA_W-1:0] pos_in,
  input  logic              err_n,
  input  logic              warn_n,
  output logic              slo,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        state_dbg
);

  localparam int SH_W = DATA_W + 2;
  localparam logic [5:0]  ACK_LAST  = 6'(ACK_LEN - 1);
  localparam logic [5:0]  DATA_LAST = 6'(DATA_W - 1);
  localparam logic [5:0]  CRC_LAST  = 6'd4;
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYC - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_START, S_CDS, S_DATA, S_NE, S_NW, S_CRC, S_TOUT
  } state_t;

  typedef enum logic [1:0] {
    CRC_HOLD, CRC_CLR, CRC_FEED, CRC_SHIFT
  } crc_op_t;

  state_t            state_q, state_d;
  logic              slo_q, slo_d;
  logic              done_q, done_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  crc_op_t           crc_op;
  logic              crc_tx;

  logic              ma_s1, ma_s2, ma_s3;
  logic              rise;
  logic [15:0]       tout_cnt;
  logic              tout_hit;

  // Synchronizer resets to the MA idle level so reset release never fakes a rise.
  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_s1 <= 1'b1;
      ma_s2 <= 1'b1;
      ma_s3 <= 1'b1;
    end else begin
      ma_s1 <= ma_in;
      ma_s2 <= ma_s1;
      ma_s3 <= ma_s2;
    end
  end

  assign rise = ma_s2 & ~ma_s3;

  // Cleared on the rise cycle and while MA is low, so the hit lands TIMEOUT_CYC cycles after synced MA goes high.
  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      tout_cnt <= '0;
    end else if (rise || !ma_s2) begin
      tout_cnt <= '0;
    end else if (tout_cnt != 16'hFFFF) begin
      tout_cnt <= tout_cnt + 16'd1;
    end
  end

  assign tout_hit = ma_s2 && !rise && (tout_cnt == TOUT_LAST);

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slo_q   <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      slo_q   <= slo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // Each state names the field currently on slo; a rise drives the next bit.
  always_comb begin
    state_d = state_q;
    slo_d   = slo_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    crc_op  = CRC_HOLD;
    if (tout_hit && state_q != S_IDLE) begin
      state_d = S_IDLE;
      slo_d   = 1'b1;
    end else if (rise) begin
      case (state_q)
        S_IDLE: begin
          sh_d    = {pos_in, err_n, warn_n};
          cnt_d   = '0;
          crc_op  = CRC_CLR;
          slo_d   = 1'b0;
          state_d = S_ACK;
        end
        S_ACK: begin
          if (cnt_q == ACK_LAST) begin
            slo_d   = 1'b1;
            state_d = S_START;
          end else begin
            slo_d = 1'b0;
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_START: begin
          slo_d   = 1'b0;
          state_d = S_CDS;
        end
        S_CDS: begin
          slo_d   = sh_q[SH_W-1];
          sh_d    = sh_q << 1;
          crc_op  = CRC_FEED;
          cnt_d   = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          slo_d  = sh_q[SH_W-1];
          sh_d   = sh_q << 1;
          crc_op = CRC_FEED;
          if (cnt_q == DATA_LAST) begin
            state_d = S_NE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_NE: begin
          slo_d   = sh_q[SH_W-1];
          sh_d    = sh_q << 1;
          crc_op  = CRC_FEED;
          state_d = S_NW;
        end
        S_NW: begin
          slo_d   = crc_tx;
          crc_op  = CRC_SHIFT;
          cnt_d   = '0;
          state_d = S_CRC;
        end
        S_CRC: begin
          slo_d  = crc_tx;
          crc_op = CRC_SHIFT;
          if (cnt_q == CRC_LAST) begin
            done_d  = 1'b1;
            state_d = S_TOUT;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_TOUT: begin
          slo_d = 1'b0;
        end
        default: begin
          slo_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

`ifdef BISSC_SLAVE_CRC_EN
  logic [5:0] crc_q;
  logic       crc_fb;

  assign crc_fb = sh_q[SH_W-1] ^ crc_q[5];
  assign crc_tx = ~crc_q[5];

  // CRC6 x^6+x+1 over data, nE and nW; shifted out MSB first afterwards.
  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      case (crc_op)
        CRC_CLR:   crc_q <= '0;
        CRC_FEED:  crc_q <= {crc_q[4:0], 1'b0} ^ (crc_fb ? 6'h03 : 6'h00);
        CRC_SHIFT: crc_q <= {crc_q[4:0], 1'b0};
        default:   crc_q <= crc_q;
      endcase
    end
  end
`else
  logic [1:0] unused_crc_op;

  assign unused_crc_op = crc_op;
  assign crc_tx        = 1'b0;
`endif

  assign slo        = slo_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bissc_slave.sv
// Self-checking bench for bissc_slave: random MA timing and payloads against a frame model built from the field list.
module tb_bissc_slave;

  localparam int DATA_W      = 8;
  localparam int ACK_LEN     = 1;
  localparam int TIMEOUT_CYC = 200;
  localparam int FRAME_RISES = ACK_LEN + 2 + DATA_W + 2 + 6;

  logic              enc_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              ma_in   = 1'b1;
  logic [DATA_W-1:0] pos_in  = '0;
  logic              err_n   = 1'b1;
  logic              warn_n  = 1'b1;
  logic              slo;
  logic              busy;
  logic              frame_done;
  logic [3:0]        state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  int rise_idx     = 0;
  int done_cnt     = 0;
  int done_rise    = 0;

  logic [0:0] exp_q[$];

  bissc_slave #(
    .DATA_W      (DATA_W),
    .ACK_LEN     (ACK_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .enc_clk    (enc_clk),
    .rst_n      (rst_n),
    .ma_in      (ma_in),
    .pos_in     (pos_in),
    .err_n      (err_n),
    .warn_n     (warn_n),
    .slo        (slo),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 enc_clk = ~enc_clk;

  always @(negedge enc_clk) begin
    if (frame_done) begin
      done_cnt  = done_cnt + 1;
      done_rise = rise_idx;
    end
  end

  // CRC as remainder of msg * x^6 divided by x^6+x+1 (zero initial value).
  function automatic logic [5:0] crc6_ref(input logic [63:0] msg, input int nbits);
    logic [63:0] v;
    v = msg << 6;
    for (int i = nbits + 5; i >= 6; i--) begin
      if (v[i]) v = v ^ (64'h43 << (i - 6));
    end
    return v[5:0];
  endfunction

  task automatic build_expected(input logic [DATA_W-1:0] p, input logic e, input logic w);
    logic [5:0]  c;
    logic [63:0] msg;
    exp_q.delete();
    for (int i = 0; i < ACK_LEN; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(p[i]);
    exp_q.push_back(e);
    exp_q.push_back(w);
    msg = {p, e, w};
`ifdef BISSC_SLAVE_CRC_EN
    c = ~crc6_ref(msg, DATA_W + 2);
`else
    c = 6'd0;
    msg = '0;
`endif
    for (int i = 5; i >= 0; i--) exp_q.push_back(c[i]);
  endtask

  // driver: one MA low/high period, then sample slo like a master on its next rise
  task automatic ma_pulse(input int lo, input int hi, output logic sampled);
    @(negedge enc_clk);
    ma_in = 1'b0;
    repeat (lo) @(negedge enc_clk);
    ma_in = 1'b1;
    rise_idx = rise_idx + 1;
    repeat (hi) @(negedge enc_clk);
    sampled = slo;
  endtask

  task automatic wait_idle_exact(input int hi, input string tag);
    repeat (TIMEOUT_CYC + 1 - hi) @(negedge enc_clk);
    tests_run++;
    if (slo !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_before_timeout: slo=%b busy=%b, required slo=0 busy=1", tag, slo, busy);
    end
    @(negedge enc_clk);
    tests_run++;
    if (slo !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_at_timeout: slo=%b busy=%b, required slo=1 busy=0", tag, slo, busy);
    end
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] p, input logic e, input logic w,
                           input logic chg, input logic [DATA_W-1:0] p_new, input string tag);
    logic got;
    logic exp_bit;
    int   done0;
    int   hi;
    @(negedge enc_clk);
    pos_in = p;
    err_n  = e;
    warn_n = w;
    build_expected(p, e, w);
    rise_idx = 0;
    done0 = done_cnt;
    for (int k = 1; k <= FRAME_RISES; k++) begin
      ma_pulse($urandom_range(4, 8), $urandom_range(4, 8), got);
      exp_bit = exp_q.pop_front();
      tests_run++;
      if (got !== exp_bit) begin
        tests_failed++;
        $display("FAIL %s_bit%0d: slo=%b, required %b", tag, k, got, exp_bit);
      end
      if (k == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s_busy: busy=%b, required 1", tag, busy);
        end
        if (chg) begin
          pos_in = p_new;
          err_n  = ~e;
          warn_n = ~w;
        end
      end
    end
    tests_run++;
    if (done_cnt - done0 != 1 || done_rise != FRAME_RISES) begin
      tests_failed++;
      $display("FAIL %s_frame_done: pulses=%0d at rise %0d, required 1 at rise %0d",
               tag, done_cnt - done0, done_rise, FRAME_RISES);
    end
    hi = $urandom_range(4, 8);
    ma_pulse($urandom_range(4, 8), hi, got);
    tests_run++;
    if (got !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_tout_bit: slo=%b, required 0", tag, got);
    end
    wait_idle_exact(hi, tag);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge enc_clk);
      ma_in = ~ma_in;
      @(negedge enc_clk);
      tests_run++;
      if (slo !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_%0d: slo=%b busy=%b frame_done=%b, required 1 0 0", i, slo, busy, frame_done);
      end
    end
    ma_in = 1'b1;
    repeat (3) @(negedge enc_clk);
    rst_n = 1'b1;
    repeat (10) @(negedge enc_clk);
    tests_run++;
    if (slo !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
      tests_failed++;
      $display("FAIL reset_release: slo=%b busy=%b pulses=%0d, required 1 0 0", slo, busy, done_cnt);
    end
  endtask

  task automatic test_known_frame;
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, "known");
  endtask

  task automatic test_abort;
    logic got;
    int   done0;
    int   hi;
    done0 = done_cnt;
    rise_idx = 0;
    for (int k = 0; k < 4; k++) ma_pulse($urandom_range(4, 8), $urandom_range(4, 8), got);
    hi = $urandom_range(4, 8);
    ma_pulse($urandom_range(4, 8), hi, got);
    wait_idle_exact(hi, "abort");
    tests_run++;
    if (done_cnt != done0) begin
      tests_failed++;
      $display("FAIL abort_done: pulses=%0d, required 0", done_cnt - done0);
    end
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, "after_abort");
  endtask

  task automatic test_input_change;
    run_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8'h3C, "chg_first");
    run_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, "chg_second");
  endtask

  task automatic test_random;
    for (int f = 0; f < 5; f++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, $sformatf("rand%0d", f));
    end
  endtask

  task automatic test_reset_midframe;
    logic got;
    int   done0;
    done0 = done_cnt;
    for (int k = 0; k < 7; k++) ma_pulse($urandom_range(4, 8), $urandom_range(4, 8), got);
    @(negedge enc_clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (slo !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset: slo=%b busy=%b frame_done=%b, required 1 0 0", slo, busy, frame_done);
    end
    repeat (3) @(negedge enc_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge enc_clk);
    tests_run++;
    if (done_cnt != done0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_after: pulses=%0d busy=%b, required 0 0", done_cnt - done0, busy);
    end
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00, "after_midreset");
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_abort();
    test_input_change();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
